threshold_flag_monitor: RTL and testbench
=========================================

THRESHOLD_FLAG_MONITOR -- requirements
Module: threshold_flag_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 4, input sample width (>=1).
REQ-002 SHALL have parameter OUT_W, default 8, registered data output width (OUT_W >= DATA_W).
REQ-003 SHALL have parameter MODE, default 0: 0 = match when sample nonzero, 1 = match when sample >= THRESH.
REQ-004 SHALL have parameter THRESH, default 8, unsigned DATA_W-bit compare value (used in MODE 1 only).
REQ-005 SHALL have parameter HOLD_CNT, default 3, consecutive valid samples needed to set or clear the flag (>=1).
REQ-006 SHALL have parameter EVT_W, default 8, width of the flag event counter.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst  input  1  synchronous reset, active-high.
REQ-009 in_valid  input  1  qualifies in_data for the current cycle.
REQ-010 in_data  input  DATA_W  unsigned sample.
REQ-011 out_flag  output  1  registered debounced match flag.
REQ-012 out_data  output  OUT_W  last valid sample, zero-extended.
REQ-013 evt_count  output  EVT_W  saturating count of out_flag rising edges.

Function
REQ-014 match SHALL be combinational: MODE 0 -> in_data != 0; MODE 1 -> in_data >= THRESH, unsigned, at DATA_W bits, no sign extension.
REQ-015 Cycles with in_valid=0 SHALL leave state, run counter, out_flag, out_data and evt_count unchanged.
REQ-016 FSM states SHALL be IDLE, ARMING, FLAGGED, RELEASING; run counter width clog2(HOLD_CNT+1).
REQ-017 IDLE: valid match -> ARMING, run=1; if HOLD_CNT=1, go directly to FLAGGED instead.
REQ-018 ARMING: valid match -> run+1; when run+1 = HOLD_CNT -> FLAGGED, run=0; valid non-match -> IDLE, run=0.
REQ-019 FLAGGED: valid non-match -> RELEASING, run=1 (HOLD_CNT=1: directly IDLE); valid match -> stay, run=0.
REQ-020 RELEASING: valid non-match -> run+1; when run+1 = HOLD_CNT -> IDLE, run=0; valid match -> FLAGGED, run=0.
REQ-021 out_flag SHALL be 1 exactly in FLAGGED and RELEASING, registered, rising on the edge accepting the HOLD_CNT-th consecutive match (one-cycle latency from that sample).
REQ-022 out_data SHALL load {zeros, in_data} on every valid cycle; one-cycle latency.
REQ-023 evt_count SHALL increment by 1 on each out_flag 0->1 transition and saturate at all-ones without wrap.
REQ-024 All arithmetic SHALL be explicitly sized; no integer-typed temporaries; no implicit truncation or widening between ports.

Reset
REQ-025 rst=1 SHALL force IDLE, run=0, out_flag=0, out_data=0, evt_count=0 on the next rising edge, overriding any in_valid in that cycle.
REQ-026 Reset asserted mid-ARMING or mid-RELEASING SHALL discard the partial run; first post-reset cycle is processed normally.

Structure
REQ-027 Shared package flag_mon_pkg SHALL hold the FSM state typedef and MODE_NONZERO=0 / MODE_THRESH=1 constants.
REQ-028 Event counter SHALL be a sub-module sat_counter (parameter W; inputs clk, rst, inc; output count).
REQ-029 Parameter legality (OUT_W>=DATA_W, HOLD_CNT>=1, MODE in {0,1}) SHALL be checked at elaboration.

Verification (DATA_W=4, OUT_W=8, MODE=1, THRESH=8, HOLD_CNT=3, EVT_W=2)
REQ-030 Valid samples 9,10,12 back-to-back -> out_flag=1 the cycle after sample 12; evt_count=1; out_data=0x0C.
REQ-031 Samples 9,10,3,9,10 -> out_flag stays 0 (run broken by 3); flag only after a further matching sample.
REQ-032 Flag set, then 2,2,9,2,2,2 -> out_flag stays 1 until the edge after the third consecutive 2, then 0.
REQ-033 Samples 9, gap (in_valid=0 two cycles), 10,11 -> out_flag=1 after 11; gaps neither break nor advance the run.
REQ-034 Five set/clear cycles -> evt_count reaches 3 and holds at 3.
REQ-035 rst=1 during ARMING with in_valid=1, in_data=15 -> all outputs 0 next cycle; 3 further matches required to flag.

Source files
------------

// File: rtl/flag_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flag_mon_pkg: shared FSM state type and match-mode constants           |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package flag_mon_pkg;

  localparam MODE_NONZERO = 0;
  localparam MODE_THRESH  = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_FLAGGED   = 2'd2,
    ST_RELEASING = 2'd3
  } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter: W-bit up counter that sticks at all-ones                  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] c_max = {W{1'b1}};
  localparam logic [W-1:0] c_one = W'(1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != c_max)) begin
      r_count <= r_count + c_one;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/threshold_flag_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | threshold_flag_monitor: debounced sample-match flag with event count   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module threshold_flag_monitor
  import flag_mon_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int OUT_W    = 8,
  parameter int MODE     = 0,
  parameter int THRESH   = 8,
  parameter int HOLD_CNT = 3,
  parameter int EVT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_flag,
  output logic [OUT_W-1:0]  out_data,
  output logic [EVT_W-1:0]  evt_count
);

  localparam RUN_W = $clog2(HOLD_CNT + 1);
  localparam logic [RUN_W-1:0] c_hold = RUN_W'(HOLD_CNT);
  localparam logic [RUN_W-1:0] c_one  = RUN_W'(1);

  if (OUT_W < DATA_W) begin : g_chk_out_w
    $error("threshold_flag_monitor: OUT_W must be >= DATA_W");
  end
  if (HOLD_CNT < 1) begin : g_chk_hold
    $error("threshold_flag_monitor: HOLD_CNT must be >= 1");
  end
  if ((MODE != MODE_NONZERO) && (MODE != MODE_THRESH)) begin : g_chk_mode
    $error("threshold_flag_monitor: MODE must be 0 or 1");
  end

  logic w_match;

  if (MODE == MODE_THRESH) begin : g_mode_thresh
    localparam logic [DATA_W-1:0] c_thresh = DATA_W'(THRESH);
    assign w_match = (in_data >= c_thresh);
  end else begin : g_mode_nonzero
    assign w_match = |in_data;
  end

  fsm_state_t       r_state, w_state_next;
  logic [RUN_W-1:0] r_run, w_run_next, w_run_inc;
  logic             r_flag, w_flag_next, w_evt_inc;
  logic [OUT_W-1:0] r_data;

  assign w_run_inc = r_run + c_one;

  // Run counter tracks consecutive samples opposing the current flag level.
  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run;
    if (in_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_match) begin
            if (c_hold == c_one) begin
              w_state_next = ST_FLAGGED;
              w_run_next   = '0;
            end else begin
              w_state_next = ST_ARMING;
              w_run_next   = c_one;
            end
          end
        end
        ST_ARMING: begin
          if (!w_match) begin
            w_state_next = ST_IDLE;
            w_run_next   = '0;
          end else if (w_run_inc == c_hold) begin
            w_state_next = ST_FLAGGED;
            w_run_next   = '0;
          end else begin
            w_run_next   = w_run_inc;
          end
        end
        ST_FLAGGED: begin
          if (w_match) begin
            w_run_next   = '0;
          end else if (c_hold == c_one) begin
            w_state_next = ST_IDLE;
            w_run_next   = '0;
          end else begin
            w_state_next = ST_RELEASING;
            w_run_next   = c_one;
          end
        end
        ST_RELEASING: begin
          if (w_match) begin
            w_state_next = ST_FLAGGED;
            w_run_next   = '0;
          end else if (w_run_inc == c_hold) begin
            w_state_next = ST_IDLE;
            w_run_next   = '0;
          end else begin
            w_run_next   = w_run_inc;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_run_next   = '0;
        end
      endcase
    end
  end

  assign w_flag_next = (w_state_next == ST_FLAGGED) || (w_state_next == ST_RELEASING);
  assign w_evt_inc   = w_flag_next && !r_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
      r_flag  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= w_run_next;
      r_flag  <= w_flag_next;
      if (in_valid) begin
        r_data <= OUT_W'(in_data);
      end
    end
  end

  sat_counter #(
    .W (EVT_W)
  ) u_evt_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_evt_inc),
    .count (evt_count)
  );

  assign out_flag = r_flag;
  assign out_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_threshold_flag_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_threshold_flag_monitor: directed + random checks vs. debounce model |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_threshold_flag_monitor;

  localparam int DATA_W   = 4;
  localparam int OUT_W    = 8;
  localparam int MODE     = 1;
  localparam int THRESH   = 8;
  localparam int HOLD_CNT = 3;
  localparam int EVT_W    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_flag;
  logic [OUT_W-1:0]  out_data;
  logic [EVT_W-1:0]  evt_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: flag level, length of the current opposing streak,
  // last accepted sample, and number of flag assertions (capped).
  logic m_flag;
  int   m_streak;
  int   m_data;
  int   m_evt;

  threshold_flag_monitor #(
    .DATA_W   (DATA_W),
    .OUT_W    (OUT_W),
    .MODE     (MODE),
    .THRESH   (THRESH),
    .HOLD_CNT (HOLD_CNT),
    .EVT_W    (EVT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_flag  (out_flag),
    .out_data  (out_data),
    .evt_count (evt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic v, input int d);
    bit opposing;
    if (r) begin
      m_flag = 1'b0; m_streak = 0; m_data = 0; m_evt = 0;
    end else if (v) begin
      m_data   = d;
      opposing = m_flag ? (d < THRESH) : (d >= THRESH);
      m_streak = opposing ? m_streak + 1 : 0;
      if (m_streak == HOLD_CNT) begin
        m_streak = 0;
        m_flag   = ~m_flag;
        if (m_flag && m_evt < (1 << EVT_W) - 1) m_evt++;
      end
    end
  endtask

  task automatic step(input logic v, input int d, input logic r = 1'b0);
    rst      = r;
    in_valid = v;
    in_data  = DATA_W'(d);
    @(posedge clk);
    model(r, v, d);
    #1;
    chk("out_flag",  32'(out_flag),  32'(m_flag));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("evt_count", 32'(evt_count), 32'(m_evt));
  endtask

  task automatic feed(input int samples[$]);
    foreach (samples[i]) step(1'b1, samples[i]);
  endtask

  initial begin
    m_flag = 1'b0; m_streak = 0; m_data = 0; m_evt = 0;

    step(1'b1, 5, 1'b1);
    step(1'b0, 0, 1'b1);
    chk("reset_flag", 32'(out_flag), 32'd0);
    chk("reset_evt",  32'(evt_count), 32'd0);

    // 9,10,12 sets the flag the edge after 12
    feed('{9, 10});
    chk("arming_flag", 32'(out_flag), 32'd0);
    step(1'b1, 12);
    chk("set_flag", 32'(out_flag), 32'd1);
    chk("set_evt",  32'(evt_count), 32'd1);
    chk("set_data", 32'(out_data), 32'h0C);

    // broken run
    step(1'b0, 0, 1'b1);
    feed('{9, 10, 3, 9, 10});
    chk("broken_flag", 32'(out_flag), 32'd0);
    step(1'b1, 11);
    chk("rearm_flag", 32'(out_flag), 32'd1);

    // release with an interrupting match
    feed('{2, 2, 9, 2, 2});
    chk("hold_flag", 32'(out_flag), 32'd1);
    step(1'b1, 2);
    chk("release_flag", 32'(out_flag), 32'd0);

    // gaps neither break nor advance the run
    step(1'b1, 9);
    step(1'b0, 15);
    step(1'b0, 0);
    step(1'b1, 10);
    chk("gap_flag_pre", 32'(out_flag), 32'd0);
    step(1'b1, 11);
    chk("gap_flag", 32'(out_flag), 32'd1);
    feed('{0, 0, 0});

    // five set/clear cycles saturate the 2-bit event counter
    for (int c = 0; c < 5; c++) begin
      feed('{8, 15, 13});
      feed('{7, 0, 1});
    end
    chk("sat_evt", 32'(evt_count), 32'd3);

    // reset mid-arming discards the partial run
    feed('{9, 10});
    step(1'b1, 15, 1'b1);
    chk("rst_flag", 32'(out_flag), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_evt",  32'(evt_count), 32'd0);
    feed('{9, 10});
    chk("post_rst_flag_pre", 32'(out_flag), 32'd0);
    step(1'b1, 11);
    chk("post_rst_flag", 32'(out_flag), 32'd1);

    // random traffic, biased so runs of matches/non-matches occur
    for (int n = 0; n < 600; n++) begin
      logic v, r;
      int   d;
      v = ($urandom_range(3) != 0);
      r = ($urandom_range(59) == 0);
      d = ($urandom_range(1) != 0) ? int'($urandom_range(15, 8)) : int'($urandom_range(7, 0));
      step(v, d, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
